// File: rtl/imm_enc_pkg.sv
// imm_enc_pkg: opcodes, instruction formats and decode/range helpers shared by the encoder
package imm_enc_pkg;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {FMT_I, FMT_S, FMT_U, FMT_SB, FMT_UJ, FMT_NONE} fmt_e;

   typedef struct packed {
      fmt_e        fmt;
      logic        range_err;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } s1_t;

   // JALR with a non-zero funct3 has no I-type meaning, so it is packed as a branch
   function automatic fmt_e decode_fmt(input logic [6:0] op, input logic [2:0] f3);
      return (op == OP_IMM || op == OP_LOAD || (op == OP_JALR && f3 == 3'b000)) ? FMT_I :
             op == OP_STORE ? FMT_S :
             op == OP_LUI ? FMT_U :
             (op == OP_BRANCH || op == OP_JALR) ? FMT_SB :
             op == OP_JAL ? FMT_UJ : FMT_NONE;
   endfunction

   function automatic logic fits(input logic [63:0] v, input int unsigned n);
      logic [63:0] t;
      t = 64'($signed(v) >>> (n - 1));
      return t == '0 || t == '1;
   endfunction

   function automatic logic range_err(input fmt_e f, input logic [63:0] v);
      case (f)
         FMT_I, FMT_S: return !fits(v, 12);
         FMT_U:        return v[11:0] != '0 || !fits(v, 32);
         FMT_SB:       return v[0] || !fits(v, 13);
         FMT_UJ:       return v[0] || !fits(v, 21);
         default:      return 1'b0;
      endcase
   endfunction
endpackage

// File: rtl/imm_encoder_pack.sv
// imm_pack: scatters register fields and immediate bits into a 32-bit RISC-V instruction word
module imm_pack
   import imm_enc_pkg::*;
(
   input  fmt_e        fmt_i,
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [31:0] imm_i,
   output logic [31:0] instr_o
);
   always_comb begin
      instr_o = {25'd0, opcode_i};
      case (fmt_i)
         FMT_I:   instr_o[31:7] = {imm_i[11:0], rs1_i, funct3_i, rd_i};
         FMT_S:   instr_o[31:7] = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0]};
         FMT_U:   instr_o[31:7] = {imm_i[31:12], rd_i};
         FMT_SB:  instr_o[31:7] = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11]};
         FMT_UJ:  instr_o[31:7] = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i};
         default: ;
      endcase
   end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready RISC-V instruction encoder with immediate range checking
// Define IMM_ENC_STATS_EN to build the saturating emitted/error word counters.
module imm_encoder
   import imm_enc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_opcode,
   input  logic [2:0]       in_funct3,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [63:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_range_err,
   output logic             out_unsup,
   output logic [CNT_W-1:0] stat_enc_cnt,
   output logic [CNT_W-1:0] stat_err_cnt
);
   s1_t         s1_d, s1_q;
   logic        s1_valid_q, s2_valid_q, s2_load;
   logic [31:0] instr_d, instr_q;
   logic        rerr_q, unsup_q;

   assign s2_load  = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_load;

   always_comb begin
      s1_d.fmt       = decode_fmt(in_opcode, in_funct3);
      s1_d.range_err = range_err(s1_d.fmt, in_imm);
      s1_d.opcode    = in_opcode;
      s1_d.funct3    = in_funct3;
      s1_d.rd        = in_rd;
      s1_d.rs1       = in_rs1;
      s1_d.rs2       = in_rs2;
      s1_d.imm       = in_imm[31:0];
   end

   imm_pack u_pack (
      .fmt_i    (s1_q.fmt),
      .opcode_i (s1_q.opcode),
      .funct3_i (s1_q.funct3),
      .rd_i     (s1_q.rd),
      .rs1_i    (s1_q.rs1),
      .rs2_i    (s1_q.rs2),
      .imm_i    (s1_q.imm),
      .instr_o  (instr_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_valid_q <= 1'b0;
         instr_q    <= '0;
         rerr_q     <= 1'b0;
         unsup_q    <= 1'b0;
      end else begin
         if (in_ready) s1_valid_q <= in_valid;
         if (in_valid && in_ready) s1_q <= s1_d;
         if (s2_load) s2_valid_q <= s1_valid_q;
         if (s2_load && s1_valid_q) begin
            instr_q <= instr_d;
            rerr_q  <= s1_q.range_err;
            unsup_q <= s1_q.fmt == FMT_NONE;
         end
      end
   end

   assign out_valid     = s2_valid_q;
   assign out_instr     = instr_q;
   assign out_range_err = rerr_q;
   assign out_unsup     = unsup_q;

`ifdef IMM_ENC_STATS_EN
   logic [CNT_W-1:0] enc_q, err_q;
   logic             xfer;

   assign xfer = s2_valid_q && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_q <= '0;
         err_q <= '0;
      end else begin
         if (xfer && !(&enc_q)) enc_q <= enc_q + CNT_W'(1);
         if (xfer && (rerr_q || unsup_q) && !(&err_q)) err_q <= err_q + CNT_W'(1);
      end
   end

   assign stat_enc_cnt = enc_q;
   assign stat_err_cnt = err_q;
`else
   assign stat_enc_cnt = '0;
   assign stat_err_cnt = '0;
`endif
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized and directed checks of imm_encoder against an arithmetic reference model
module tb_imm_encoder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [6:0]  in_opcode = '0;
   logic [2:0]  in_funct3 = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [63:0] in_imm = '0;
   logic        out_valid, out_ready = 1'b0;
   logic [31:0] out_instr;
   logic        out_range_err, out_unsup;
   logic [15:0] stat_enc_cnt, stat_err_cnt;

   typedef struct {
      logic [31:0] instr;
      logic        rerr;
      logic        unsup;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0, checks = 0;
   int          n_out = 0, n_err = 0;
   bit          mon_en = 1'b0, rand_rdy = 1'b0;
   logic        stall_q = 1'b0;
   logic [31:0] held_q = '0;

   imm_encoder #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_range_err(out_range_err), .out_unsup(out_unsup),
      .stat_enc_cnt(stat_enc_cnt), .stat_err_cnt(stat_err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic bit in_rng(input longint s, input int bits);
      longint lim;
      lim = longint'(1) << (bits - 1);
      return s >= -lim && s < lim;
   endfunction

   // Reference: format chosen by opcode, range judged on the signed integer value
   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm);
      exp_t   e;
      longint s;
      s = longint'(imm);
      e.instr = {25'd0, op};
      e.rerr  = 1'b0;
      e.unsup = 1'b0;
      if (op == 7'h13 || op == 7'h03 || (op == 7'h67 && f3 == 3'd0)) begin
         e.instr = {imm[11:0], rs1, f3, rd, op};
         e.rerr  = !in_rng(s, 12);
      end else if (op == 7'h23) begin
         e.instr = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
         e.rerr  = !in_rng(s, 12);
      end else if (op == 7'h37) begin
         e.instr = {imm[31:12], rd, op};
         e.rerr  = (s % 4096 != 0) || !in_rng(s, 32);
      end else if (op == 7'h63 || op == 7'h67) begin
         e.instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
         e.rerr  = (s % 2 != 0) || !in_rng(s, 13);
      end else if (op == 7'h6F) begin
         e.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         e.rerr  = (s % 2 != 0) || !in_rng(s, 21);
      end else begin
         e.unsup = 1'b1;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (mon_en && rst_n) begin
         if (stall_q) begin
            checks++;
            if (out_valid !== 1'b1 || out_instr !== held_q) begin
               errors++;
               $display("FAIL hold_stable got valid=%b instr=%h expected valid=1 instr=%h", out_valid, out_instr, held_q);
            end
         end
         stall_q = out_valid && !out_ready;
         held_q  = out_instr;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word got=%h expected no word", out_instr);
            end else begin
               e = exp_q.pop_front();
               n_out++;
               if (e.rerr || e.unsup) n_err++;
               if ({out_instr, out_range_err, out_unsup} !== {e.instr, e.rerr, e.unsup}) begin
                  errors++;
                  $display("FAIL out_word got=%h rerr=%b unsup=%b expected=%h rerr=%b unsup=%b",
                           out_instr, out_range_err, out_unsup, e.instr, e.rerr, e.unsup);
               end
            end
         end
      end else begin
         stall_q = 1'b0;
      end
   end

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm, input exp_t e);
      int t = 0;
      in_valid = 1'b1;
      in_opcode = op; in_funct3 = f3; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      if (rand_rdy) out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         @(posedge clk); #1;
         if (rand_rdy) out_ready = $urandom_range(0, 3) != 0;
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout got in_ready=0 expected 1 within 100 cycles");
      end else exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm);
      drive(op, f3, rd, rs1, rs2, imm, model(op, f3, rd, rs1, rs2, imm));
   endtask

   task automatic wait_drain();
      int t = 0;
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk); #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending words expected 0", exp_q.size());
      end
   endtask

   task automatic check_stats(input string tag);
      int enc_e, err_e;
`ifdef IMM_ENC_STATS_EN
      enc_e = n_out; err_e = n_err;
`else
      enc_e = 0; err_e = 0;
`endif
      checks++;
      if (int'(stat_enc_cnt) != enc_e || int'(stat_err_cnt) != err_e) begin
         errors++;
         $display("FAIL stats_%s got enc=%0d err=%0d expected enc=%0d err=%0d", tag, stat_enc_cnt, stat_err_cnt, enc_e, err_e);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({out_valid, out_instr, out_range_err, out_unsup, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state got valid=%b instr=%h rerr=%b unsup=%b in_ready=%b expected 0/0/0/0/1",
                  out_valid, out_instr, out_range_err, out_unsup, in_ready);
      end
      check_stats("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;
   endtask

   task automatic test_errors();
      exp_t e;
      out_ready = 1'b1;
      e = '{32'h80000093, 1'b1, 1'b0}; drive(7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd2048, e);
      e = '{32'h002000EF, 1'b1, 1'b0}; drive(7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 64'd3, e);
      e = '{32'h00000033, 1'b0, 1'b1}; drive(7'h33, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0, e);
      wait_drain();
      check_stats("errors");
   endtask

   task automatic test_directed();
      exp_t e;
      out_ready = 1'b1;
      e = '{32'hFFF00093, 1'b0, 1'b0};
      exp_q.push_back(e);
      in_valid = 1'b1; in_opcode = 7'h13; in_funct3 = 3'd0; in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0;
      in_imm = 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early got out_valid=%b expected 0 one cycle after accept", out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'hFFF00093) begin
         errors++;
         $display("FAIL latency_addi got valid=%b instr=%h expected valid=1 instr=fff00093", out_valid, out_instr);
      end
      e = '{32'h00113423, 1'b0, 1'b0}; drive(7'h23, 3'd3, 5'd0, 5'd2, 5'd1, 64'd8, e);
      e = '{32'hFE000EE3, 1'b0, 1'b0}; drive(7'h63, 3'd0, 5'd0, 5'd0, 5'd0, -64'sd4, e);
      e = '{32'h123452B7, 1'b0, 1'b0}; drive(7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 64'h12345000, e);
      e = '{32'h001000EF, 1'b0, 1'b0}; drive(7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 64'd2048, e);
      wait_drain();
      check_stats("directed");
   endtask

   task automatic test_backpressure();
      logic [63:0] imms[3] = '{64'd1, 64'd2, 64'd3};
      int          idx = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         in_valid = idx < 3; in_opcode = 7'h13; in_funct3 = 3'd0; in_rd = 5'(idx + 1); in_rs1 = 5'd4; in_rs2 = 5'd0;
         in_imm = imms[idx % 3];
         @(negedge clk);
         if (in_valid && in_ready) begin
            exp_q.push_back(model(7'h13, 3'd0, 5'(idx + 1), 5'd4, 5'd0, imms[idx % 3]));
            idx++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (idx != 2 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== exp_q[0].instr) begin
         errors++;
         $display("FAIL backpressure got accepted=%0d in_ready=%b valid=%b instr=%h expected 2/0/1/%h",
                  idx, in_ready, out_valid, out_instr, exp_q[0].instr);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL release_stream got out_valid=%b expected 1 at cycle %0d", out_valid, k);
         end
         if (k == 0) begin
            checks++;
            if (in_ready !== 1'b1) begin
               errors++;
               $display("FAIL full_accept got in_ready=%b expected 1 while draining", in_ready);
            end else begin
               exp_q.push_back(model(7'h13, 3'd0, 5'd3, 5'd4, 5'd0, imms[2]));
            end
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      wait_drain();
      check_stats("backpressure");
   endtask

   task automatic test_random();
      logic [6:0]  ops[8] = '{7'h13, 7'h03, 7'h23, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h33};
      logic [63:0] imm;
      logic [31:0] r;
      rand_rdy = 1'b1;
      for (int n = 0; n < 250; n++) begin
         r = $urandom();
         case ($urandom_range(0, 4))
            0: imm = {{52{r[11]}}, r[11:0]};
            1: imm = {{51{r[12]}}, r[12:1], 1'b0};
            2: imm = {{43{r[20]}}, r[20:0]};
            3: imm = {{32{r[31]}}, r[31:12], 12'd0};
            default: imm = {$urandom(), r};
         endcase
         send(ops[$urandom_range(0, 7)], 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            out_ready = $urandom_range(0, 3) != 0;
         end
      end
      wait_drain();
      check_stats("random");
   endtask

   task automatic test_reset_mid();
      exp_t e;
      e = '{32'h0, 1'b0, 1'b0};
      out_ready = 1'b0;
      drive(7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd5, e);
      drive(7'h13, 3'd0, 5'd2, 5'd0, 5'd0, 64'd6, e);
      mon_en = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_pipe got valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0) begin
         errors++;
         $display("FAIL async_flush got valid=%b instr=%h expected 0/00000000", out_valid, out_instr);
      end
      exp_q.delete();
      n_out = 0; n_err = 0;
      @(negedge clk) rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset got in_ready=%b expected 1", in_ready);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_word got valid=%b instr=%h expected no word", out_valid, out_instr);
         end
      end
      check_stats("reset_mid");
      @(posedge clk); #1;
      mon_en = 1'b1;
      send(7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 64'd2048);
      wait_drain();
      check_stats("post_reset");
   endtask

   initial begin
      test_reset();
      test_errors();
      test_directed();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
